// File: rtl/peak_detector.sv
// Schmidl-Cox peak detector: finds the metric maximum inside a CP_SIZE-beat
// window after the first threshold crossing, then emits frame_len samples
// starting at the input sample that carried the peak.
module peak_detector #(
    parameter int          FFT_SIZE     = 1024,
    parameter int unsigned CP_SIZE      = 128,
    parameter int          METRIC_WIDTH = 32 + $clog2(CP_SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic [METRIC_WIDTH-1:0]    threshold,
    input  logic [15:0]                frame_len,
    input  logic [METRIC_WIDTH-1:0]    m_tdata,
    input  logic                       m_tlast,
    input  logic                       m_tvalid,
    output logic                       m_tready,
    input  logic [31:0]                s_tdata,
    input  logic                       s_tlast,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic [31:0]                o_tdata,
    output logic                       o_tlast,
    output logic                       o_tvalid,
    input  logic                       o_tready,
    output logic                       detect,
    output logic [METRIC_WIDTH-1:0]    peak_value,
    output logic [$clog2(CP_SIZE)-1:0] peak_offset
);

    localparam int CW = $clog2(CP_SIZE + 1);
    localparam int OW = $clog2(CP_SIZE);
    localparam int DW = 32 * CP_SIZE;

    typedef enum logic [1:0] {IDLE, SEARCH, ALIGN, FRAME} state_t;

    state_t                  state;
    logic [DW-1:0]           dly;
    logic [31:0]             popped;
    logic                    out_free;
    logic                    beat;
    logic                    new_max;
    logic                    win_done;
    logic [METRIC_WIDTH-1:0] max_val;
    logic [METRIC_WIDTH-1:0] max_next;
    logic [CW-1:0]           win_cnt;
    logic [OW-1:0]           offset;
    logic [OW-1:0]           off_next;
    logic [OW-1:0]           align_cnt;
    logic [15:0]             flen_q;
    logic [15:0]             emit_cnt;
    logic [31:0]             unused_fft;
    logic                    unused_sink;

    // Stream tlast flags and the symbol length carry no information here.
    assign unused_fft  = 32'(FFT_SIZE);
    assign unused_sink = ^{m_tlast, s_tlast, unused_fft};

    // Both input streams advance together only when the output slice can accept.
    assign out_free = !o_tvalid || o_tready;
    assign beat     = m_tvalid && s_tvalid && out_free && !clear;
    assign m_tready = reset_n && !clear && s_tvalid && out_free;
    assign s_tready = reset_n && !clear && m_tvalid && out_free;

    assign popped   = dly[DW-1 -: 32];

    // Search-window bookkeeping for the current beat; strict compare keeps the earliest peak.
    assign new_max  = m_tdata > max_val;
    assign max_next = new_max ? m_tdata : max_val;
    assign off_next = new_max ? win_cnt[OW-1:0] : offset;
    assign win_done = win_cnt == CW'(CP_SIZE - 1);

    // Sample delay line: each beat shifts in s_tdata and exposes the sample from CP_SIZE beats ago.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly <= '0;
        end else if (clear) begin
            dly <= '0;
        end else if (beat) begin
            dly <= {dly[DW-33:0], s_tdata};
        end
    end

    // Detection FSM with registered output slice and peak reporting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            o_tdata     <= '0;
            o_tlast     <= 1'b0;
            o_tvalid    <= 1'b0;
            detect      <= 1'b0;
            peak_value  <= '0;
            peak_offset <= '0;
            max_val     <= '0;
            win_cnt     <= '0;
            offset      <= '0;
            align_cnt   <= '0;
            flen_q      <= '0;
            emit_cnt    <= '0;
        end else if (clear) begin
            state       <= IDLE;
            o_tdata     <= '0;
            o_tlast     <= 1'b0;
            o_tvalid    <= 1'b0;
            detect      <= 1'b0;
            peak_value  <= '0;
            peak_offset <= '0;
            max_val     <= '0;
            win_cnt     <= '0;
            offset      <= '0;
            align_cnt   <= '0;
            flen_q      <= '0;
            emit_cnt    <= '0;
        end else begin
            detect <= 1'b0;
            if (o_tready) begin
                o_tvalid <= 1'b0;
                o_tlast  <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (beat && m_tdata > threshold) begin
                        flen_q  <= (frame_len == 16'd0) ? 16'd1 : frame_len;
                        max_val <= m_tdata;
                        offset  <= '0;
                        win_cnt <= CW'(1);
                        state   <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (beat) begin
                        win_cnt <= win_cnt + CW'(1);
                        max_val <= max_next;
                        offset  <= off_next;
                        if (win_done) begin
                            detect      <= 1'b1;
                            peak_value  <= max_next;
                            peak_offset <= off_next;
                            align_cnt   <= off_next;
                            // A zero offset skips ALIGN so no cycle is lost between window and frame.
                            state       <= (off_next == '0) ? FRAME : ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    // Leaving on the beat that discards the last pre-peak sample keeps one beat per cycle.
                    if (align_cnt == '0) begin
                        state <= FRAME;
                    end else if (beat) begin
                        align_cnt <= align_cnt - OW'(1);
                        if (align_cnt == OW'(1)) begin
                            state <= FRAME;
                        end
                    end
                end
                FRAME: begin
                    if (beat) begin
                        o_tdata  <= popped;
                        o_tvalid <= 1'b1;
                        if (emit_cnt == flen_q - 16'd1) begin
                            o_tlast  <= 1'b1;
                            emit_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            o_tlast  <= 1'b0;
                            emit_cnt <= emit_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peak_detector.sv
// Directed bench for peak_detector with CP_SIZE=4, threshold=100, sample n = n.
module tb_peak_detector;

    localparam int MW = 35;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic [MW-1:0] threshold;
    logic [15:0]   frame_len;
    logic [MW-1:0] m_tdata;
    logic          m_tlast, m_tvalid, m_tready;
    logic [31:0]   s_tdata;
    logic          s_tlast, s_tvalid, s_tready;
    logic [31:0]   o_tdata;
    logic          o_tlast, o_tvalid, o_tready;
    logic          detect;
    logic [MW-1:0] peak_value;
    logic [1:0]    peak_offset;

    peak_detector #(
        .FFT_SIZE    (16),
        .CP_SIZE     (4),
        .METRIC_WIDTH(MW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .threshold  (threshold),
        .frame_len  (frame_len),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .detect     (detect),
        .peak_value (peak_value),
        .peak_offset(peak_offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] m0, m1, m2, m3, base;
        bit            stall;
        logic [15:0]   flen;
        int            exp_det;
        logic [MW-1:0] exp_pv;
        int            exp_po;
        int            first;
        int            cnt;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    logic [MW-1:0] mtab [0:127];
    int            n;
    bit            stall;
    logic [31:0]   cap_d [$];
    bit            cap_l [$];
    logic [MW-1:0] det_pv [$];
    int            det_po [$];
    bit            held_valid;
    logic [31:0]   held_data;
    int            stab_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive();
        m_tdata = (n < 128) ? mtab[n] : '0;
        s_tdata = 32'(n);
    endtask

    // One clock: observe at the falling edge, update stimulus just after the rising edge.
    task automatic step();
        bit took;
        @(negedge clk);
        took = m_tvalid && m_tready;
        if (held_valid && (!o_tvalid || o_tdata != held_data)) stab_err++;
        if (o_tvalid && o_tready) begin
            cap_d.push_back(o_tdata);
            cap_l.push_back(o_tlast);
        end
        held_valid = o_tvalid && !o_tready;
        held_data  = o_tdata;
        if (detect) begin
            det_pv.push_back(peak_value);
            det_po.push_back(int'(peak_offset));
        end
        @(posedge clk);
        #1;
        if (took) n++;
        o_tready = stall ? !o_tready : 1'b1;
        drive();
    endtask

    task automatic clear_logs();
        cap_d.delete();
        cap_l.delete();
        det_pv.delete();
        det_po.delete();
        held_valid = 1'b0;
        stab_err   = 0;
    endtask

    task automatic reset_dut(input logic [15:0] fl);
        reset_n   = 1'b0;
        clear     = 1'b0;
        frame_len = fl;
        n         = 0;
        o_tready  = 1'b1;
        clear_logs();
        drive();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_seq(input string tag, input int idx, input int first, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            logic [31:0] d;
            bit          l;
            d = (idx + k < cap_d.size()) ? cap_d[idx + k] : 32'hFFFF_FFFF;
            l = (idx + k < cap_l.size()) ? cap_l[idx + k] : 1'b0;
            check($sformatf("%s_data%0d", tag, k), d, first + k);
            check($sformatf("%s_last%0d", tag, k), l, k == cnt - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        vec_t v;

        vecs[0] = '{150, 200, 180, 120, 0,   1'b0, 16, 1, 200, 1, 11, 16};
        vecs[1] = '{200, 200, 50,  50,  0,   1'b0, 16, 1, 200, 0, 10, 16};
        vecs[2] = '{150, 200, 180, 120, 0,   1'b1, 16, 1, 200, 1, 11, 16};
        vecs[3] = '{100, 100, 100, 100, 100, 1'b0, 16, 0, 0,   0, 0,  0};
        vecs[4] = '{101, 0,   0,   0,   0,   1'b0, 0,  1, 101, 0, 10, 1};
        vecs[5] = '{101, 102, 103, 104, 0,   1'b0, 3,  1, 104, 3, 13, 3};

        threshold = MW'(100);
        m_tlast   = 1'b0;
        s_tlast   = 1'b0;
        m_tvalid  = 1'b1;
        s_tvalid  = 1'b1;
        o_tready  = 1'b1;
        clear     = 1'b0;
        frame_len = 16'd16;
        stall     = 1'b0;
        n         = 0;
        for (int j = 0; j < 128; j++) mtab[j] = '0;
        drive();

        // Reset state
        reset_n = 1'b0;
        #2;
        check("rst_m_tready", m_tready, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tlast", o_tlast, 0);
        check("rst_o_tdata", o_tdata, 0);
        check("rst_detect", detect, 0);
        check("rst_peak_value", peak_value, 0);
        check("rst_peak_offset", peak_offset, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_rst_m_tready", m_tready, 1);
        check("post_rst_s_tready", s_tready, 1);

        // Table-driven scenarios
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            for (int j = 0; j < 128; j++) mtab[j] = v.base;
            mtab[10] = v.m0;
            mtab[11] = v.m1;
            mtab[12] = v.m2;
            mtab[13] = v.m3;
            stall = v.stall;
            reset_dut(v.flen);
            for (int c = 0; c < 120; c++) step();
            check($sformatf("v%0d_detects", i), det_pv.size(), v.exp_det);
            check($sformatf("v%0d_peak_value", i), peak_value, v.exp_pv);
            check($sformatf("v%0d_peak_offset", i), peak_offset, v.exp_po);
            check($sformatf("v%0d_out_count", i), cap_d.size(), v.cnt);
            check_seq($sformatf("v%0d", i), 0, v.first, v.cnt);
            check($sformatf("v%0d_stall_hold", i), stab_err, 0);
        end
        stall = 1'b0;

        // Asynchronous reset in the middle of a frame, then a fresh crossing at n=40
        for (int j = 0; j < 128; j++) mtab[j] = '0;
        mtab[10] = 150; mtab[11] = 200; mtab[12] = 180; mtab[13] = 120;
        mtab[40] = 150;
        reset_dut(16'd16);
        for (int c = 0; c < 100 && cap_d.size() < 5; c++) step();
        check("h1_five_out", cap_d.size(), 5);
        check_seq("h1_pre", 0, 11, 0);
        for (int k = 0; k < 5; k++) check($sformatf("h1_pre_last%0d", k), (k < cap_l.size()) ? cap_l[k] : 1'b1, 0);
        reset_n = 1'b0;
        #1;
        check("h1_rst_o_tvalid", o_tvalid, 0);
        check("h1_rst_o_tlast", o_tlast, 0);
        check("h1_rst_o_tdata", o_tdata, 0);
        check("h1_rst_m_tready", m_tready, 0);
        check("h1_rst_peak_value", peak_value, 0);
        #1;
        reset_n = 1'b1;
        clear_logs();
        for (int c = 0; c < 80; c++) step();
        check("h1_detects", det_pv.size(), 1);
        check("h1_peak_offset", peak_offset, 0);
        check("h1_peak_value", peak_value, 150);
        check("h1_out_count", cap_d.size(), 16);
        check_seq("h1_post", 0, 40, 16);

        // Crossings during FRAME and on its final beat are ignored; next IDLE crossing detects
        for (int j = 0; j < 128; j++) mtab[j] = '0;
        mtab[10] = 150; mtab[11] = 200; mtab[12] = 180; mtab[13] = 120;
        mtab[20] = 250; mtab[30] = 250; mtab[40] = 150;
        reset_dut(16'd16);
        for (int c = 0; c < 90; c++) step();
        check("h2_detects", det_pv.size(), 2);
        check("h2_first_pv", (det_pv.size() > 0) ? det_pv[0] : '0, 200);
        check("h2_second_pv", (det_pv.size() > 1) ? det_pv[1] : '0, 150);
        check("h2_second_po", (det_po.size() > 1) ? det_po[1] : -1, 0);
        check("h2_out_count", cap_d.size(), 32);
        check_seq("h2_f0", 0, 11, 16);
        check_seq("h2_f1", 16, 40, 16);

        // Synchronous clear abandons a frame without o_tlast
        for (int j = 0; j < 128; j++) mtab[j] = '0;
        mtab[10] = 150; mtab[11] = 200; mtab[12] = 180; mtab[13] = 120;
        reset_dut(16'd16);
        for (int c = 0; c < 100 && cap_d.size() < 3; c++) step();
        check("h3_three_out", cap_d.size(), 3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("h3_clr_o_tvalid", o_tvalid, 0);
        check("h3_clr_o_tdata", o_tdata, 0);
        check("h3_clr_peak_value", peak_value, 0);
        check("h3_clr_peak_offset", peak_offset, 0);
        for (int c = 0; c < 40; c++) step();
        check("h3_out_count", cap_d.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("h3_data%0d", k), (k < cap_d.size()) ? cap_d[k] : 32'hFFFF_FFFF, 11 + k);
            check($sformatf("h3_last%0d", k), (k < cap_l.size()) ? cap_l[k] : 1'b1, 0);
        end
        check("h3_detects", det_pv.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
